// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// cache_fill_fsm : fetches a missing cache block word by word and fills it
// Revision 1.0
// ============================================================================
module cache_fill_fsm #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int OFF_W       = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_miss_detected,
  input  logic [ADDR_W-1:0]         i_miss_address,
  input  logic                      i_memory_data_valid,
  input  logic [15:0]               i_memory_data,
  output logic                      o_fsm_busy,
  output logic                      o_memory_read_en,
  output logic [ADDR_W-1:0]         o_memory_address,
  output logic                      o_write_data_array,
  output logic [OFF_W-1:0]          o_cache_word_offset,
  output logic [15:0]               o_cache_fill_data,
  output logic                      o_write_tag_array,
  output logic [ADDR_W-OFF_W-2:0]   o_fill_tag
);

  localparam int                TAG_W        = ADDR_W - OFF_W - 1;
  localparam logic [OFF_W:0]    c_ISSUE_LAST = (OFF_W+1)'(BLOCK_WORDS - 1);
  localparam logic [OFF_W:0]    c_ISSUE_ONE  = (OFF_W+1)'(1);
  localparam logic [OFF_W-1:0]  c_RECV_LAST  = OFF_W'(BLOCK_WORDS - 1);
  localparam logic [OFF_W-1:0]  c_RECV_ONE   = OFF_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t           r_state;
  logic [TAG_W-1:0] r_base;
  logic [OFF_W:0]   r_issue_cnt;
  logic [OFF_W-1:0] r_recv_cnt;
  logic             r_busy;
  logic             r_read_en;

  logic [OFF_W-1:0] w_req_off;
  logic             w_write;
  logic             w_last;

  // Once all requests are out the counter sits at BLOCK_WORDS; clamp so the
  // address keeps showing the final word instead of wrapping to word 0.
  assign w_req_off = r_issue_cnt[OFF_W] ? {OFF_W{1'b1}} : r_issue_cnt[OFF_W-1:0];
  assign w_write   = (r_state == S_FILL) && i_memory_data_valid;
  assign w_last    = w_write && (r_recv_cnt == c_RECV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_busy      <= 1'b0;
      r_read_en   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_miss_detected) begin
            r_state     <= S_FILL;
            r_base      <= i_miss_address[ADDR_W-1:OFF_W+1];
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_busy      <= 1'b1;
            r_read_en   <= 1'b1;
          end
        end
        S_FILL: begin
          if (r_read_en) begin
            r_issue_cnt <= r_issue_cnt + c_ISSUE_ONE;
            if (r_issue_cnt == c_ISSUE_LAST) begin
              r_read_en <= 1'b0;
            end
          end
          if (i_memory_data_valid) begin
            r_recv_cnt <= r_recv_cnt + c_RECV_ONE;
            if (r_recv_cnt == c_RECV_LAST) begin
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_read_en <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_fsm_busy          = r_busy;
  assign o_memory_read_en    = r_read_en;
  assign o_memory_address    = {r_base, w_req_off, 1'b0};
  assign o_write_data_array  = w_write;
  assign o_cache_word_offset = r_recv_cnt;
  assign o_cache_fill_data   = i_memory_data;
  assign o_write_tag_array   = w_last;
  assign o_fill_tag          = r_base;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// tb_cache_fill_fsm : randomized fills against a behavioural memory/cache model
// Revision 1.0
// ============================================================================
module tb_cache_fill_fsm;

  localparam int BW = 8;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        miss  = 1'b0;
  logic [15:0] maddr = '0;
  logic        valid = 1'b0;
  logic [15:0] mdata = '0;

  logic        o_fsm_busy;
  logic        o_memory_read_en;
  logic [15:0] o_memory_address;
  logic        o_write_data_array;
  logic [2:0]  o_cache_word_offset;
  logic [15:0] o_cache_fill_data;
  logic        o_write_tag_array;
  logic [11:0] o_fill_tag;

  cache_fill_fsm #(.ADDR_W(16), .BLOCK_WORDS(8), .OFF_W(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_miss_detected     (miss),
    .i_miss_address      (maddr),
    .i_memory_data_valid (valid),
    .i_memory_data       (mdata),
    .o_fsm_busy          (o_fsm_busy),
    .o_memory_read_en    (o_memory_read_en),
    .o_memory_address    (o_memory_address),
    .o_write_data_array  (o_write_data_array),
    .o_cache_word_offset (o_cache_word_offset),
    .o_cache_fill_data   (o_cache_fill_data),
    .o_write_tag_array   (o_write_tag_array),
    .o_fill_tag          (o_fill_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0, n_checks = 0, n_fail = 0, n_wr = 0, n_tag = 0;

  // Behavioural view of the fill: how many words requested/received so far.
  bit m_busy = 1'b0;
  int m_base = 0, m_issued = 0, m_recvd = 0;

  // Memory responder: in-order return queue with per-request due cycle.
  typedef struct { int due; logic [15:0] data; } ret_t;
  ret_t rq[$];
  int   lat = 4, gap_max = 0, last_due = -100;
  bit   stray = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 1'b0; m_base = 0; m_issued = 0; m_recvd = 0;
    end else if (!m_busy) begin
      if (miss) begin
        m_busy = 1'b1; m_base = int'(maddr) / 16; m_issued = 0; m_recvd = 0;
      end
    end else begin
      if (m_issued < BW) m_issued++;
      if (valid) begin
        m_recvd++;
        if (m_recvd == BW) m_busy = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      valid = 1'b1;
      mdata = rq[0].data;
      void'(rq.pop_front());
    end else begin
      valid = stray && !m_busy;
      mdata = 16'($urandom);
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      bit exp_rd, exp_wr;
      exp_rd = m_busy && (m_issued < BW);
      exp_wr = m_busy && valid;
      chk("fsm_busy", o_fsm_busy, m_busy);
      chk("read_en", o_memory_read_en, exp_rd);
      if (exp_rd) chk("mem_addr", o_memory_address, 32'(m_base * 16 + 2 * m_issued));
      chk("write_data", o_write_data_array, exp_wr);
      chk("write_tag", o_write_tag_array, exp_wr && (m_recvd == BW - 1));
      if (exp_wr) begin
        chk("word_offset", o_cache_word_offset, 32'(m_recvd));
        chk("fill_data", o_cache_fill_data, mdata);
      end
      chk("fill_tag", o_fill_tag, 32'(m_base));
      if (o_memory_read_en) begin
        int d, g;
        g = $urandom_range(gap_max, 0);
        d = cyc + lat;
        if (d < last_due + 1 + g) d = last_due + 1 + g;
        last_due = d;
        rq.push_back('{d, 16'($urandom)});
      end
      if (o_write_data_array) n_wr++;
      if (o_write_tag_array)  n_tag++;
    end
  end

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_fsm_busy) return;
    end
    timeout("wait_busy");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!o_fsm_busy && rq.size() == 0) return;
    end
    timeout("wait_idle");
  endtask

  task automatic do_fill(input logic [15:0] addr, input int l, input int g);
    int tag0;
    tag0    = n_tag;
    lat     = l;
    gap_max = g;
    maddr   = addr;
    miss    = 1'b1;
    wait_busy();
    miss    = 1'b0;
    maddr   = 16'($urandom);
    wait_idle();
    chk("tags_per_fill", 32'(n_tag - tag0), 32'd1);
  endtask

  initial begin
    int t0, wr0, tag0;

    // Reset with stray returns on the bus.
    stray = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", o_fsm_busy, 1'b0);
    chk("rst_read_en", o_memory_read_en, 1'b0);
    chk("rst_tag", o_fill_tag, 12'h000);
    chk("rst_addr", o_memory_address, 16'h0000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);

    // Miss 0x1236 with 4-cycle memory; miss_address disturbed mid-fill.
    lat = 4; gap_max = 0;
    maddr = 16'h1236; miss = 1'b1; t0 = cyc;
    for (int rel = 1; rel <= 13; rel++) begin
      @(negedge clk);
      chk("d_busy", o_fsm_busy, (rel <= 12));
      chk("d_read_en", o_memory_read_en, (rel <= 8));
      if (rel <= 8) chk("d_addr", o_memory_address, 32'(16'h1230 + 2 * (rel - 1)));
      chk("d_write", o_write_data_array, (rel >= 5 && rel <= 12));
      if (rel >= 5 && rel <= 12) chk("d_offset", o_cache_word_offset, 32'(rel - 5));
      chk("d_tag_wr", o_write_tag_array, (rel == 12));
      if (rel == 12) chk("d_fill_tag", o_fill_tag, 12'h123);
      chk("d_cycle", 32'(cyc - t0), 32'(rel));
      miss = 1'b0;
      if (rel == 3) maddr = 16'h4000;
    end
    wait_idle();

    // Top-of-memory block: no wrap past 0xFFFE.
    do_fill(16'hFFFF, 3, 1);
    chk("top_fill_tag", o_fill_tag, 12'hFFF);

    // Reset asserted in cycle 7 of a fill; in-flight returns arrive afterwards.
    @(negedge clk);
    lat = 4; gap_max = 0;
    maddr = 16'h2468; miss = 1'b1;
    for (int rel = 1; rel <= 8; rel++) begin
      @(negedge clk);
      miss = 1'b0;
      if (rel == 7) rst = 1'b1;
      if (rel == 8) begin
        rst = 1'b0;
        chk("r_busy", o_fsm_busy, 1'b0);
        chk("r_read_en", o_memory_read_en, 1'b0);
        chk("r_write", o_write_data_array, 1'b0);
        chk("r_tag_wr", o_write_tag_array, 1'b0);
        chk("r_fill_tag", o_fill_tag, 12'h000);
        chk("r_offset", o_cache_word_offset, 3'd0);
      end
    end
    wr0 = n_wr; tag0 = n_tag;
    stray = 1'b1;
    repeat (10) @(negedge clk);
    stray = 1'b0;
    chk("r_no_writes", 32'(n_wr - wr0), 32'd0);
    chk("r_no_tags", 32'(n_tag - tag0), 32'd0);
    wait_idle();

    // Irregular returns and a one-cycle-latency burst.
    do_fill(16'hBEEF, 1, 0);
    for (int i = 0; i < 12; i++) begin
      do_fill(16'($urandom), $urandom_range(6, 1), $urandom_range(3, 0));
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    // Miss held across completion: refill starts on the first idle cycle.
    tag0 = n_tag;
    lat = 2; gap_max = 1;
    maddr = 16'h5A5A; miss = 1'b1; stray = 1'b1;
    wait_busy();
    begin
      bit fell;
      fell = 1'b0;
      for (int i = 0; i < 100 && !fell; i++) begin
        @(negedge clk);
        if (!o_fsm_busy) fell = 1'b1;
      end
      if (!fell) timeout("b2b_fall");
    end
    chk("b2b_gap_read_en", o_memory_read_en, 1'b0);
    @(negedge clk);
    chk("b2b_busy", o_fsm_busy, 1'b1);
    chk("b2b_read_en", o_memory_read_en, 1'b1);
    chk("b2b_addr", o_memory_address, 16'h5A50);
    miss = 1'b0;
    wait_idle();
    stray = 1'b0;
    chk("b2b_tags", 32'(n_tag - tag0), 32'd2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
